// File: rtl/riscv_crypto_issue.sv
// rtl/riscv_crypto_issue.sv - scalar-crypto issue stage: RV32 decode into a 2-entry FIFO
// Decodes AES32/SHA256/SHA512/SM3/SM4 encodings into a one-hot control bus.
module riscv_crypto_issue #(
  parameter bit ILLEGAL_FWD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_instruction,
  output logic [31:0] out_rs1,
  output logic [31:0] out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_illegal,
  output logic [15:0] illegal_count
);

  typedef struct packed {
    logic [19:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] funct12;
  logic        unused_fields;

  assign opcode        = in_instr[6:0];
  assign funct3        = in_instr[14:12];
  assign funct7        = in_instr[31:25];
  assign funct12       = in_instr[31:20];
  assign unused_fields = ^{in_instr[19:15], in_instr[11:7]};

  logic [17:0] dec_ops;
  logic        dec_bs;
  logic        dec_illegal;
  logic [19:0] dec_instr;

  // bs-carrying ops have funct7[4]=1 while the sha512 group has funct7[4:3]=01, so both cases never overlap
  always_comb begin
    dec_ops = '0;
    dec_bs  = 1'b0;
    if (opcode == 7'b0110011 && funct3 == 3'b000) begin
      case (funct7[4:0])
        5'b10001: begin dec_ops[17] = 1'b1; dec_bs = 1'b1; end
        5'b10011: begin dec_ops[16] = 1'b1; dec_bs = 1'b1; end
        5'b10101: begin dec_ops[15] = 1'b1; dec_bs = 1'b1; end
        5'b10111: begin dec_ops[14] = 1'b1; dec_bs = 1'b1; end
        5'b11000: begin dec_ops[0]  = 1'b1; dec_bs = 1'b1; end
        5'b11010: begin dec_ops[1]  = 1'b1; dec_bs = 1'b1; end
        default: ;
      endcase
      case (funct7)
        7'h28:   dec_ops[9] = 1'b1;
        7'h29:   dec_ops[8] = 1'b1;
        7'h2A:   dec_ops[7] = 1'b1;
        7'h2B:   dec_ops[5] = 1'b1;
        7'h2E:   dec_ops[6] = 1'b1;
        7'h2F:   dec_ops[4] = 1'b1;
        default: ;
      endcase
    end else if (opcode == 7'b0010011 && funct3 == 3'b001) begin
      case (funct12)
        12'h100: dec_ops[11] = 1'b1;
        12'h101: dec_ops[10] = 1'b1;
        12'h102: dec_ops[13] = 1'b1;
        12'h103: dec_ops[12] = 1'b1;
        12'h108: dec_ops[3]  = 1'b1;
        12'h109: dec_ops[2]  = 1'b1;
        default: ;
      endcase
    end
    dec_illegal = (dec_ops == '0);
    dec_instr   = {(dec_bs ? in_instr[31:30] : 2'b00), dec_ops};
  end

  entry_t      mem_q [2];
  entry_t      mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        in_ready_q, in_ready_d;
  logic [15:0] illegal_count_q, illegal_count_d;
  logic        accept, push, pop;

  always_comb begin
    accept   = in_valid & in_ready_q;
    push     = accept & (~dec_illegal | ILLEGAL_FWD);
    pop      = (count_q != 2'd0) & out_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {dec_instr, in_rs1, in_rs2, in_rd, dec_illegal};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // registered ready: decided from the occupancy the FIFO will have next cycle
    in_ready_d = (count_d < 2'd2);
    illegal_count_d = illegal_count_q;
    if (accept && dec_illegal && illegal_count_q != 16'hFFFF) begin
      illegal_count_d = illegal_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]        <= '0;
      mem_q[1]        <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      in_ready_q      <= 1'b0;
      illegal_count_q <= 16'd0;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      in_ready_q      <= in_ready_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  entry_t head;
  assign head            = mem_q[rd_ptr_q];
  assign in_ready        = in_ready_q;
  assign out_valid       = (count_q != 2'd0);
  assign out_instruction = head.instr;
  assign out_rs1         = head.rs1;
  assign out_rs2         = head.rs2;
  assign out_rd          = head.rd;
  assign out_illegal     = head.illegal;
  assign illegal_count   = illegal_count_q;

endmodule
